// File: rtl/haze_recover_pkg.sv
// Shared constants for the dehaze recovery pipeline: widths, pixel packing, reciprocal ROM contents.
// Pure definitions, no logic; consumers add their own latency and do not stall.
package haze_recover_pkg;

  localparam int T_MIN_DEFAULT = 26;
  localparam int LATENCY       = 4;
  localparam int RECIP_W       = 20;
  localparam int FRAC_W        = 16;

  localparam int PIX_W  = 24;
  localparam int CH_W   = 8;
  localparam int NUM_CH = 3;
  localparam int R_LSB  = 16;
  localparam int G_LSB  = 8;
  localparam int B_LSB  = 0;

  localparam int DIFF_W  = CH_W + 1;
  localparam int PROD_W  = 30;
  localparam int WHOLE_W = PROD_W - FRAC_W;
  localparam int J_W     = WHOLE_W + 1;

  // floor(2^16 * 255 / t); t = 0 never reaches the ROM once floored, saturate it anyway.
  function automatic logic [RECIP_W-1:0] recip_of(input int t);
    int q;
    if (t == 0) q = (1 << RECIP_W) - 1;
    else        q = (255 << FRAC_W) / t;
    return q[RECIP_W-1:0];
  endfunction

endpackage

// File: rtl/haze_recip_lut.sv
// Reciprocal ROM: recip = floor(2^16*255/t_eff), registered; latency 1 cycle.
// Free-running, no backpressure.
module haze_recip_lut
  import haze_recover_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [CH_W-1:0]    t_eff,
  output logic [RECIP_W-1:0] recip
);

  logic [RECIP_W-1:0] rom [256];

  for (genvar i = 0; i < 256; i++) begin : g_rom
    assign rom[i] = recip_of(i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) recip <= '0;
    else        recip <= rom[t_eff];
  end

endmodule

// File: rtl/haze_recover.sv
// Dehaze recovery J = (I - A) / max(t, T_MIN) + A per channel, clamped to 8 bits; latency 4 cycles.
// Free-running pipeline, no backpressure; sync outputs are the src sync delayed 4 cycles.
module haze_recover
  import haze_recover_pkg::*;
#(
  parameter int T_MIN = T_MIN_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pre_src_frame_vsync,
  input  logic              pre_src_frame_href,
  input  logic              pre_src_frame_clken,
  input  logic [PIX_W-1:0]  pre_img,
  input  logic              pre_tx_frame_vsync,
  input  logic              pre_tx_frame_href,
  input  logic              pre_tx_frame_clken,
  input  logic [CH_W-1:0]   pre_tx_img,
  input  logic [CH_W-1:0]   pre_A,
  output logic              post_frame_vsync,
  output logic              post_frame_href,
  output logic              post_frame_clken,
  output logic [PIX_W-1:0]  post_img,
  output logic              align_err
);

  localparam logic [CH_W-1:0] T_FLOOR = CH_W'(T_MIN);

  logic                     vs_d;
  logic [CH_W-1:0]          a_frame;
  logic                     vs_rise;
  logic [CH_W-1:0]          a_use;
  logic [CH_W-1:0]          t_floored;
  logic                     misalign;
  logic                     unused_tx_href;

  logic [2:0]               sync_q [LATENCY];
  logic [CH_W-1:0]          t1;
  logic [CH_W-1:0]          a1, a2, a3;
  logic signed [DIFF_W-1:0] diff_n [NUM_CH];
  logic signed [DIFF_W-1:0] diff1  [NUM_CH];
  logic signed [DIFF_W-1:0] diff2  [NUM_CH];
  logic signed [PROD_W-1:0] prod3  [NUM_CH];
  logic [RECIP_W-1:0]       recip2;
  logic [PIX_W-1:0]         pix_n;

  assign unused_tx_href = pre_tx_frame_href;

  assign vs_rise   = pre_src_frame_vsync & ~vs_d;
  assign a_use     = vs_rise ? pre_A : a_frame;
  assign t_floored = (pre_tx_img < T_FLOOR) ? T_FLOOR : pre_tx_img;
  assign misalign  = (pre_src_frame_clken != pre_tx_frame_clken) ||
                     (pre_src_frame_vsync != pre_tx_frame_vsync);

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      diff_n[c] = $signed({1'b0, pre_img[c*CH_W +: CH_W]}) - $signed({1'b0, a_use});
    end
  end

  // Stage 2 reciprocal comes out of the ROM register, aligned with diff2/a2.
  haze_recip_lut u_recip (
    .clk   (clk),
    .rst_n (rst_n),
    .t_eff (t1),
    .recip (recip2)
  );

  // Stage 4: integer part of the scaled difference is a floor, then re-add A and clamp.
  always_comb begin
    logic signed [WHOLE_W-1:0] whole;
    logic signed [J_W-1:0]     jw;
    pix_n = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      whole = $signed(prod3[c][PROD_W-1:FRAC_W]);
      jw    = $signed({whole[WHOLE_W-1], whole}) + $signed({{(J_W-CH_W){1'b0}}, a3});
      if (jw < 0)                 pix_n[c*CH_W +: CH_W] = '0;
      else if (jw > J_W'(255))    pix_n[c*CH_W +: CH_W] = 8'hFF;
      else                        pix_n[c*CH_W +: CH_W] = jw[CH_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d      <= 1'b0;
      a_frame   <= '0;
      align_err <= 1'b0;
      t1        <= '0;
      a1        <= '0;
      a2        <= '0;
      a3        <= '0;
      post_img  <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        diff1[c] <= '0;
        diff2[c] <= '0;
        prod3[c] <= '0;
      end
      for (int i = 0; i < LATENCY; i++) sync_q[i] <= '0;
    end else begin
      vs_d <= pre_src_frame_vsync;
      if (vs_rise) a_frame <= pre_A;
      if (misalign) align_err <= 1'b1;

      sync_q[0] <= {pre_src_frame_vsync, pre_src_frame_href, pre_src_frame_clken};
      for (int i = 1; i < LATENCY; i++) sync_q[i] <= sync_q[i-1];

      t1 <= t_floored;
      a1 <= a_use;
      a2 <= a1;
      a3 <= a2;
      for (int c = 0; c < NUM_CH; c++) begin
        diff1[c] <= diff_n[c];
        diff2[c] <= diff1[c];
        prod3[c] <= PROD_W'(diff2[c]) * PROD_W'($signed({1'b0, recip2}));
      end

      post_img <= sync_q[LATENCY-2][0] ? pix_n : '0;
    end
  end

  assign post_frame_vsync = sync_q[LATENCY-1][2];
  assign post_frame_href  = sync_q[LATENCY-1][1];
  assign post_frame_clken = sync_q[LATENCY-1][0];

endmodule

// File: doc/haze_recover.md
HAZE_RECOVER -- requirements
Module: haze_recover

Interface
REQ-001 clk  input  1  pixel clock; all state on its rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 pre_src_frame_vsync / pre_src_frame_href / pre_src_frame_clken  input  1 each  source-image sync, already aligned to the transmission stream.
REQ-004 pre_img  input  24  hazy pixel {R[23:16],G[15:8],B[7:0]}, valid when pre_src_frame_clken=1.
REQ-005 pre_tx_frame_vsync / pre_tx_frame_href / pre_tx_frame_clken  input  1 each  transmission-map sync.
REQ-006 pre_tx_img  input  8  transmission t, where 255 represents 1.0.
REQ-007 pre_A  input  8  atmospheric light estimate.
REQ-008 post_frame_vsync / post_frame_href / post_frame_clken  output  1 each  sync delayed by LATENCY.
REQ-009 post_img  output  24  recovered pixel J, same channel packing as pre_img.
REQ-010 align_err  output  1  sticky flag: src and tx qualifiers disagreed.
REQ-011 Parameter T_MIN, default 26: transmission floor (about 0.1).
REQ-012 Parameter LATENCY, fixed 4: input-to-output pipeline depth in cycles.

Function
REQ-013 Pipeline free-runs with no stall, and all sync outputs equal the src sync inputs delayed exactly 4 cycles.
REQ-014 Frame A: a_frame loads pre_A in the cycle where pre_src_frame_vsync is 1 and was 0 in the previous cycle.
REQ-015 In that same vsync-rising-edge cycle, the pixel path uses pre_A directly (bypass); in all other cycles it uses a_frame.
REQ-016 Stage 1 registers t_eff = max(pre_tx_img, T_MIN), diff_c = {1'b0,I_c} - {1'b0,A} as 9-bit signed per channel, and A.
REQ-017 Stage 2 registers recip = floor(2^16*255/t_eff) as 20-bit unsigned; t_eff=255 gives recip=65536.
REQ-018 Stage 3 registers prod_c = diff_c * recip as 30-bit signed per channel.
REQ-019 Stage 4 computes J_c = (prod_c >>> 16) + A, where the shift is arithmetic (floor), and clamps J_c to [0,255].
REQ-020 post_img is 0 in any cycle where post_frame_clken=0.
REQ-021 align_err sets when pre_src_frame_clken != pre_tx_frame_clken or pre_src_frame_vsync != pre_tx_frame_vsync, and clears only on reset.
REQ-022 A misalignment does not alter the datapath; tx data is used as presented.
REQ-023 Asserting rst_n mid-frame flushes all pipeline stages; outputs are 0 in the first cycle after reset release.
REQ-024 Pixels arriving before the first vsync rise use a_frame = 0.

Reset
REQ-025 All outputs, all pipeline registers, a_frame, the vsync-edge register and align_err reset to 0 asynchronously.
REQ-026 Reset release is synchronised by the integrator; the block adds no reset synchroniser.

Structure
REQ-027 Shared package holds T_MIN, LATENCY=4, RECIP_W=20, FRAC_W=16 and the 24-bit pixel packing constants.
REQ-028 Sub-module haze_recip_lut: 8-bit t_eff in, registered 20-bit recip out, one-cycle latency; it is a ROM built by constant function or initial table.
REQ-029 Three per-channel datapaths in the top level share one recip value.

Verification
REQ-030 A=200 at vsync rise, t=128, I=(100,150,200) -> post_img=(0,100,200) exactly 4 cycles after input.
REQ-031 t=255, any A, I=(17,128,240) -> post_img=(17,128,240).
REQ-032 t=10 (floored to 26, recip=642756), A=200, I=(255,200,0) -> R clamps to 255, G=200, B clamps to 0.
REQ-033 pre_A changes mid-frame from 200 to 50 -> recovered pixels keep using A=200 until the next vsync rise; the rising-edge cycle uses the new pre_A.
REQ-034 Drive tx_clken low for one cycle while src_clken=1 -> align_err=1 from the next cycle, and it stays 1 across frames until reset.
REQ-035 Assert rst_n low mid-line with a full pipeline -> all outputs are 0 immediately, and no stale pixel appears after release.
